// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a write scoreboard.
// Reads are combinational with write bypass. Each register has a pending bit that
// marks an outstanding producer, so decode can stall on a hazard. x0 reads as zero.
module regfile_scoreboard #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 2,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic [NWRITE-1:0]      we,
    input  logic [NWRITE*AW-1:0]   waddr,
    input  logic [NWRITE*XLEN-1:0] wdata,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_addr,
    input  logic                   flush,
    output logic [AW:0]            pend_cnt
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;
    logic [NREGS-1:0] wr_hit;
    logic [AW:0]      pend_cnt_q, pend_cnt_d;

    // Next register contents: later (higher) write ports override earlier ones.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int unsigned j = 0; j < NWRITE; j++) begin
            if (we[j] && (waddr[j*AW +: AW] != '0)) begin
                regs_d[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    // Registers that any port writes this cycle (clears a pending producer).
    always_comb begin
        wr_hit = '0;
        for (int unsigned j = 0; j < NWRITE; j++) begin
            if (we[j]) begin
                wr_hit[waddr[j*AW +: AW]] = 1'b1;
            end
        end
    end

    // Scoreboard next state: issue beats flush, flush beats write, write beats hold.
    always_comb begin
        pending_d  = '0;
        pend_cnt_d = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (issue_valid && (issue_addr == AW'(r))) begin
                pending_d[r] = 1'b1;
            end else if (flush) begin
                pending_d[r] = 1'b0;
            end else if (wr_hit[r]) begin
                pending_d[r] = 1'b0;
            end else begin
                pending_d[r] = pending_q[r];
            end
        end
        for (int unsigned r = 0; r < NREGS; r++) begin
            pend_cnt_d = pend_cnt_d + (AW + 1)'(pending_d[r]);
        end
    end

    // State update; async reset clears data, pending bits and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Read ports: bypass from the highest matching write port, x0 forced to zero.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data;
            logic            hit;
            addr = rd_addr[i*AW +: AW];
            data = regs_q[addr];
            hit  = 1'b0;
            for (int unsigned j = 0; j < NWRITE; j++) begin
                if (we[j] && (waddr[j*AW +: AW] == addr)) begin
                    data = wdata[j*XLEN +: XLEN];
                    hit  = 1'b1;
                end
            end
            if (addr == '0) begin
                data = '0;
            end
            rd_data[i*XLEN +: XLEN] = data;
            rd_busy[i] = pending_q[addr] && !hit && (addr != '0);
        end
    end

    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, a reset
// corner sequence, and a random phase checked against a behavioural model.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [5:0]  pend_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
        .issue_addr(issue_addr), .flush(flush), .pend_cnt(pend_cnt)
    );

    typedef struct {
        logic [4:0]  ra0, ra1;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iv;
        logic [4:0]  ia;
        logic        fl;
        logic [31:0] d0, d1;
        logic        b0, b1;
        logic [5:0]  cnt;
    } vec_t;

    typedef struct {
        logic [31:0] d0, d1;
        logic        b0, b1;
    } exp_t;

    exp_t   sb_q[$];
    vec_t   vecs[24];
    logic [31:0] mregs[32];
    logic [31:0] mpend;
    logic [5:0]  mcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [1:0] w, input logic [4:0] wa0,
                                input logic [31:0] wd0, input logic [4:0] wa1,
                                input logic [31:0] wd1, input logic iv,
                                input logic [4:0] ia, input logic fl,
                                input logic [31:0] d0, input logic b0,
                                input logic [31:0] d1, input logic b1,
                                input logic [5:0] cnt);
        vec_t v;
        v.ra0 = ra0; v.ra1 = ra1; v.we = w; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1;
        v.wd1 = wd1; v.iv = iv; v.ia = ia; v.fl = fl;
        v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rd_addr     = {v.ra1, v.ra0};
        we          = v.we;
        waddr       = {v.wa1, v.wa0};
        wdata       = {v.wd1, v.wd0};
        issue_valid = v.iv;
        issue_addr  = v.ia;
        flush       = v.fl;
    endtask

    // Pop one expectation and compare the combinational read outputs against it.
    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty got 1 expected 0", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".d0"}, rd_data[31:0], e.d0);
            chk({tag, ".d1"}, rd_data[63:32], e.d1);
            chk({tag, ".b0"}, 32'(rd_busy[0]), 32'(e.b0));
            chk({tag, ".b1"}, 32'(rd_busy[1]), 32'(e.b1));
        end
    endtask

    function automatic exp_t model_read(input logic [4:0] a0, input logic [4:0] a1);
        exp_t e;
        logic [4:0]  a;
        logic [31:0] d;
        logic        b;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? a0 : a1;
            d = mregs[a];
            b = mpend[a];
            if (we[0] && waddr[4:0] == a) begin d = wdata[31:0];  b = 1'b0; end
            if (we[1] && waddr[9:5] == a) begin d = wdata[63:32]; b = 1'b0; end
            if (a == 5'd0) begin d = '0; b = 1'b0; end
            if (i == 0) begin e.d0 = d; e.b0 = b; end
            else        begin e.d1 = d; e.b1 = b; end
        end
        return e;
    endfunction

    task automatic model_update();
        logic [31:0] np;
        for (int j = 0; j < 2; j++) begin
            if (we[j] && waddr[j*5 +: 5] != 5'd0) mregs[waddr[j*5 +: 5]] = wdata[j*32 +: 32];
        end
        np = mpend;
        for (int r = 1; r < 32; r++) begin
            if (flush) np[r] = 1'b0;
            if ((we[0] && waddr[4:0] == 5'(r)) || (we[1] && waddr[9:5] == 5'(r))) begin
                if (!flush) np[r] = 1'b0;
            end
        end
        if (issue_valid && issue_addr != 5'd0) np[issue_addr] = 1'b1;
        mpend = np;
        mcnt  = 6'($countones(mpend));
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Directed table: ra0 ra1 we wa0 wd0 wa1 wd1 iv ia fl | d0 b0 d1 b1 cnt-after
        vecs[0]  = mk(5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(5, 7, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        vecs[2]  = mk(5, 5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
        vecs[3]  = mk(7, 5, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 0, 32'h22, 0, 32'hDEADBEEF, 0, 0);
        vecs[4]  = mk(7, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h22, 0, 0, 0, 0);
        vecs[5]  = mk(3, 7, 2'b00, 0, 0, 0, 0, 1, 3, 0, 0, 0, 32'h22, 0, 1);
        vecs[6]  = mk(3, 3, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        vecs[7]  = mk(3, 5, 2'b01, 3, 32'h44, 0, 0, 0, 0, 0, 32'h44, 0, 32'hDEADBEEF, 0, 0);
        vecs[8]  = mk(3, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 0, 0, 0);
        vecs[9]  = mk(4, 9, 2'b00, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1);
        vecs[10] = mk(4, 9, 2'b10, 0, 0, 9, 32'h99, 1, 9, 1, 0, 1, 32'h99, 0, 1);
        vecs[11] = mk(4, 9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99, 1, 1);
        vecs[12] = mk(4, 9, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h99, 1, 0);
        vecs[13] = mk(0, 0, 2'b01, 0, 32'hFF, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99, 0, 0);
        vecs[15] = mk(10, 0, 2'b00, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 1);
        vecs[16] = mk(10, 10, 2'b00, 0, 0, 0, 0, 1, 10, 0, 0, 1, 0, 1, 1);
        vecs[17] = mk(10, 0, 2'b11, 10, 32'hAB, 10, 32'hCD, 0, 0, 0, 32'hCD, 0, 0, 0, 0);
        vecs[18] = mk(10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hCD, 0, 0, 0, 0);
        vecs[19] = mk(11, 0, 2'b01, 11, 32'h55, 0, 0, 1, 11, 0, 32'h55, 0, 0, 0, 1);
        vecs[20] = mk(11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h55, 1, 0, 0, 1);
        vecs[21] = mk(31, 0, 2'b00, 0, 0, 0, 0, 1, 31, 0, 0, 0, 0, 0, 2);
        vecs[22] = mk(31, 11, 2'b10, 0, 0, 31, 32'h3131, 0, 0, 0, 32'h3131, 0, 32'h55, 1, 1);
        vecs[23] = mk(11, 31, 2'b00, 0, 0, 0, 0, 0, 0, 1, 32'h55, 1, 32'h3131, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        // Reset state over every address on both ports.
        chk("reset.pend_cnt", 32'(pend_cnt), 32'd0);
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            chk("reset.rd_data", rd_data[31:0] | rd_data[63:32], 32'd0);
            chk("reset.rd_busy", 32'(rd_busy), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 24; k++) begin
            drive(vecs[k]);
            e.d0 = vecs[k].d0; e.d1 = vecs[k].d1; e.b0 = vecs[k].b0; e.b1 = vecs[k].b1;
            sb_q.push_back(e);
            #1;
            sb_check($sformatf("vec%0d", k));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.pend_cnt", k), 32'(pend_cnt), 32'(vecs[k].cnt));
        end

        // Async reset mid-burst: a write and issue are in flight when rst rises.
        drive(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("rstseq.pend_pre", 32'(pend_cnt), 32'd1);
        drive(mk(13, 5, 2'b01, 12, 32'h1212, 0, 0, 1, 14, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        chk("rstseq.pend_cnt", 32'(pend_cnt), 32'd0);
        chk("rstseq.busy13", 32'(rd_busy[0]), 32'd0);
        chk("rstseq.data5", rd_data[63:32], 32'd0);
        @(posedge clk);
        #1;
        drive(mk(12, 14, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        #1;
        chk("rstseq.data12", rd_data[31:0], 32'd0);
        chk("rstseq.busy14", 32'(rd_busy[1]), 32'd0);
        @(posedge clk);
        #1;
        chk("rstseq.pend_post", 32'(pend_cnt), 32'd0);

        // Random phase against the behavioural model (state is all-zero after reset).
        for (int r = 0; r < 32; r++) mregs[r] = '0;
        mpend = '0;
        mcnt  = '0;
        for (int k = 0; k < 400; k++) begin
            rd_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            we          = 2'($urandom_range(0, 3));
            waddr       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wdata       = {$urandom(), $urandom()};
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_addr  = 5'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 15) == 0);
            sb_q.push_back(model_read(rd_addr[4:0], rd_addr[9:5]));
            #1;
            sb_check($sformatf("rnd%0d", k));
            @(posedge clk);
            model_update();
            #1;
            chk($sformatf("rnd%0d.pend_cnt", k), 32'(pend_cnt), 32'(mcnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
